// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch stage: icache lookup/response packets and buffer entries.
// No logic with latency; pure type and helper definitions.
// No flow control here; consumers define their own handshakes.
package fetch_stage_pkg;

   localparam int DEFAULT_FETCH_BUF_DEPTH = 8;

   typedef logic [63:0] MEM_BLOCK;

   // The address is carried whole and also split into the icache's view of it.
   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic [15:0] zeros;
      logic [12:0] tag;
      logic [2:0]  block_offset;
   } I_ADDR_PACKET;

   typedef struct packed {
      logic     valid;
      MEM_BLOCK data;
   } CACHE_DATA;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } FETCH_ENTRY;

   // Build a lookup packet; the split fields are just views of the address.
   function automatic I_ADDR_PACKET make_addr(input logic [31:0] a, input logic v);
      I_ADDR_PACKET p;
      p.valid        = v;
      p.addr         = a;
      p.zeros        = a[31:16];
      p.tag          = a[15:3];
      p.block_offset = a[2:0];
      return p;
   endfunction

   // A 64-bit block holds two instructions; address bit 2 picks the upper one.
   function automatic logic [31:0] word_select(input MEM_BLOCK d, input logic [31:0] a);
      return a[2] ? d[63:32] : d[31:0];
   endfunction

endpackage

// File: rtl/fetch_stage_buffer.sv
// Instruction buffer: circular FIFO, up to two pushes and two pops per cycle, with flush.
// Zero-latency read: the head and head+1 entries are visible combinationally.
// Caller pushes only when o_room2 is set; pops are clamped to the current occupancy.
module fetch_buffer
   import fetch_stage_pkg::*;
#(
   parameter int DEPTH = DEFAULT_FETCH_BUF_DEPTH
) (
   input  logic                         i_clock,
   input  logic                         i_reset,
   input  logic                         i_flush,
   input  logic [1:0]                   i_push_cnt,
   input  FETCH_ENTRY [1:0]             i_push_entry,
   input  logic [1:0]                   i_pop_req,
   output FETCH_ENTRY [1:0]             o_head,
   output logic [$clog2(DEPTH):0]       o_count,
   output logic                         o_room2
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   FETCH_ENTRY       r_mem [DEPTH];
   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [CW-1:0]    r_count;

   logic [1:0]       w_req;
   logic [1:0]       w_pop_cnt;
   logic [PW-1:0]    w_head1;
   logic [PW-1:0]    w_tail1;

   assign w_head1 = r_head + PW'(1);
   assign w_tail1 = r_tail + PW'(1);

   // Pop count is the smaller of what decode asks for (at most 2) and what is held.
   always_comb begin
      w_req     = (i_pop_req > 2'd2) ? 2'd2 : i_pop_req;
      w_pop_cnt = w_req;
      if (CW'(w_req) > r_count) begin
         w_pop_cnt = r_count[1:0];
      end
   end

   // Storage and pointers; reset clears everything, flush only empties the queue.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_push_cnt != 2'd0) begin
            r_mem[r_tail] <= i_push_entry[0];
         end
         if (i_push_cnt == 2'd2) begin
            r_mem[w_tail1] <= i_push_entry[1];
         end
         r_tail  <= r_tail + PW'(i_push_cnt);
         r_head  <= r_head + PW'(w_pop_cnt);
         r_count <= r_count + CW'(i_push_cnt) - CW'(w_pop_cnt);
      end
   end

   // Expose the two oldest entries, zeroed when not actually held.
   always_comb begin
      o_head    = '0;
      o_head[0] = (r_count >= CW'(1)) ? r_mem[r_head]  : '0;
      o_head[1] = (r_count >= CW'(2)) ? r_mem[w_head1] : '0;
   end

   assign o_count = r_count;
   assign o_room2 = (CW'(DEPTH) - r_count) >= CW'(2);

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: two-wide icache lookup at fpc/fpc+4, in-order capture into the instruction buffer.
// Lookups and decode outputs are combinational; captured instructions appear one cycle later.
// Lookups stop while fewer than two buffer slots are free; a slot-0 miss re-presents the same PC.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int          FETCH_BUF_DEPTH = DEFAULT_FETCH_BUF_DEPTH,
   parameter logic [31:0] RESET_PC        = 32'h0
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   output I_ADDR_PACKET [1:0] read_addrs,
   input  CACHE_DATA [1:0]    cache_outs,
   input  logic [1:0]         dec_ready,
   output logic [1:0]         dec_valid,
   output logic [1:0][31:0]   dec_inst,
   output logic [1:0][31:0]   dec_pc
);

   localparam int CW = $clog2(FETCH_BUF_DEPTH) + 1;

   logic [31:0]       r_fpc;
   logic [31:0]       w_pc1;
   logic              w_room2;
   logic              w_lookup;
   logic              w_hit0;
   logic              w_hit1;
   logic [1:0]        w_push_cnt;
   FETCH_ENTRY [1:0]  w_push_entry;
   FETCH_ENTRY [1:0]  w_head;
   logic [CW-1:0]     w_count;

   assign w_pc1    = r_fpc + 32'd4;
   assign w_lookup = w_room2 && !redirect_valid && !reset;

   // Capture strictly in order: slot 1 only counts when slot 0 also hit.
   always_comb begin
      w_hit0          = w_lookup && cache_outs[0].valid;
      w_hit1          = w_hit0 && cache_outs[1].valid;
      w_push_cnt      = {w_hit1, w_hit0 & ~w_hit1};
      w_push_entry    = '0;
      w_push_entry[0] = '{inst: word_select(cache_outs[0].data, r_fpc), pc: r_fpc};
      w_push_entry[1] = '{inst: word_select(cache_outs[1].data, w_pc1), pc: w_pc1};
   end

   // Fetch PC: redirect overrides; otherwise advance past whatever was captured.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_fpc <= RESET_PC;
      end else if (redirect_valid) begin
         r_fpc <= redirect_pc;
      end else begin
         r_fpc <= r_fpc + {28'd0, w_push_cnt, 2'b00};
      end
   end

   fetch_buffer #(
      .DEPTH (FETCH_BUF_DEPTH)
   ) u_buf (
      .i_clock      (clock),
      .i_reset      (reset),
      .i_flush      (redirect_valid),
      .i_push_cnt   (w_push_cnt),
      .i_push_entry (w_push_entry),
      .i_pop_req    (dec_ready),
      .o_head       (w_head),
      .o_count      (w_count),
      .o_room2      (w_room2)
   );

   // Drive lookups and decode view; everything reads as zero while reset is held.
   always_comb begin
      read_addrs = '0;
      dec_valid  = '0;
      dec_inst   = '0;
      dec_pc     = '0;
      if (!reset) begin
         read_addrs[0] = make_addr(r_fpc, w_lookup);
         read_addrs[1] = make_addr(w_pc1, w_lookup);
         dec_valid     = {w_count >= CW'(2), w_count >= CW'(1)};
         dec_inst[0]   = w_head[0].inst;
         dec_inst[1]   = w_head[1].inst;
         dec_pc[0]     = w_head[0].pc;
         dec_pc[1]     = w_head[1].pc;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic against a queue model.
// Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
// The model tracks the fetch PC and the buffered {inst, pc} pairs as plain queues.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   localparam int DEPTH = 8;

   logic               clock = 1'b0;
   logic               reset;
   logic               redirect_valid;
   logic [31:0]        redirect_pc;
   I_ADDR_PACKET [1:0] read_addrs;
   CACHE_DATA [1:0]    cache_outs;
   logic [1:0]         dec_ready;
   logic [1:0]         dec_valid;
   logic [1:0][31:0]   dec_inst;
   logic [1:0][31:0]   dec_pc;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_fpc;
   logic [31:0] m_inst [$];
   logic [31:0] m_pc   [$];

   always #5 clock = ~clock;

   fetch_stage #(
      .FETCH_BUF_DEPTH (DEPTH),
      .RESET_PC        (32'h0)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .read_addrs     (read_addrs),
      .cache_outs     (cache_outs),
      .dec_ready      (dec_ready),
      .dec_valid      (dec_valid),
      .dec_inst       (dec_inst),
      .dec_pc         (dec_pc)
   );

   function automatic logic [31:0] pick(input logic [63:0] d, input logic [31:0] a);
      if ((a % 8) >= 4) return d[63:32];
      return d[31:0];
   endfunction

   // Identifiable instruction word for address a, placed in the half a selects.
   function automatic logic [31:0] tagw(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [63:0] mk(input logic [31:0] a);
      if ((a % 8) >= 4) return {tagw(a), ~tagw(a)};
      return {~tagw(a), tagw(a)};
   endfunction

   // One clock of the reference behaviour, from the inputs currently applied.
   task automatic model_step();
      int npop;
      int npush;
      logic [31:0] a;
      if (reset) begin
         m_inst.delete(); m_pc.delete(); m_fpc = 32'h0;
      end else if (redirect_valid) begin
         m_inst.delete(); m_pc.delete(); m_fpc = redirect_pc;
      end else begin
         npush = 0;
         if ((DEPTH - m_inst.size()) >= 2 && cache_outs[0].valid)
            npush = cache_outs[1].valid ? 2 : 1;
         npop = (int'(dec_ready) < m_inst.size()) ? int'(dec_ready) : m_inst.size();
         repeat (npop) begin
            void'(m_inst.pop_front());
            void'(m_pc.pop_front());
         end
         for (int i = 0; i < npush; i++) begin
            a = m_fpc + 32'(4 * i);
            m_pc.push_back(a);
            m_inst.push_back(pick(cache_outs[i].data, a));
         end
         m_fpc = m_fpc + 32'(4 * npush);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic drive(input logic rst, input logic rv, input logic [31:0] rpc,
                        input logic [1:0] rdy, input logic h0, input logic h1,
                        input logic [63:0] d0, input logic [63:0] d1);
      reset          = rst;
      redirect_valid = rv;
      redirect_pc    = rpc;
      dec_ready      = rdy;
      cache_outs[0]  = '{valid: h0, data: d0};
      cache_outs[1]  = '{valid: h1, data: d1};
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 64'h0, 64'h0);
      tick();
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b0, 32'h0, 2'd2, 1'b1, 1'b1, 64'hFFFF, 64'hFFFF);
      #1;
      total++;
      if (read_addrs !== '0) begin
         bad++; $display("FAIL reset_read_addrs: got %h want 0", read_addrs);
      end
      total++;
      if ({dec_valid, dec_inst, dec_pc} !== '0) begin
         bad++; $display("FAIL reset_dec: got v=%b i=%h p=%h want 0", dec_valid, dec_inst, dec_pc);
      end
      tick();
      tick();
      drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 64'h0, 64'h0);
      #1;
      total++;
      if ({dec_valid, read_addrs[0].valid, read_addrs[0].addr, read_addrs[1].addr} !== {2'b00, 1'b1, 32'h0, 32'h4}) begin
         bad++; $display("FAIL reset_release: got dv=%b rv=%b a0=%h a1=%h want 00 1 0 4",
                         dec_valid, read_addrs[0].valid, read_addrs[0].addr, read_addrs[1].addr);
      end
   endtask

   task automatic test_double_hit();
      do_reset();
      drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1, 64'h0, 64'h0);
      #1;
      total++;
      if ({read_addrs[0].valid, read_addrs[0].addr, read_addrs[1].valid, read_addrs[1].addr} !== {1'b1, 32'h0, 1'b1, 32'h4}) begin
         bad++; $display("FAIL dbl_lookup: got a0=%h a1=%h want 0/4", read_addrs[0].addr, read_addrs[1].addr);
      end
      tick();
      drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 64'h0, 64'h0);
      #1;
      total++;
      if ({dec_valid, dec_pc, read_addrs[0].addr} !== {2'b11, 32'h4, 32'h0, 32'h8}) begin
         bad++; $display("FAIL dbl_push: got dv=%b pc=%h fpc=%h want 11 4/0 8", dec_valid, dec_pc, read_addrs[0].addr);
      end
   endtask

   task automatic test_slot1_miss();
      do_reset();
      drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 64'hAAAA_0001_BBBB_0000, 64'h0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 64'h1111_2222_3333_4444, 64'h0);
      #1;
      total++;
      if (read_addrs[0].addr !== 32'h4) begin
         bad++; $display("FAIL s1miss_fpc: got %h want 4", read_addrs[0].addr);
      end
      tick();
      drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 64'h0, 64'h0);
      #1;
      total++;
      if ({dec_valid, dec_pc, dec_inst} !== {2'b11, 32'h4, 32'h0, 32'h1111_2222, 32'hBBBB_0000}) begin
         bad++; $display("FAIL s1miss_entries: got dv=%b pc=%h inst=%h", dec_valid, dec_pc, dec_inst);
      end
      total++;
      if ({read_addrs[0].addr, read_addrs[1].addr} !== {32'h8, 32'hC}) begin
         bad++; $display("FAIL s1miss_next: got %h/%h want 8/c", read_addrs[0].addr, read_addrs[1].addr);
      end
   endtask

   // Continues from test_slot1_miss: two entries held, fpc = 0x8.
   task automatic test_slot0_miss();
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 64'h0, 64'hDEAD);
         #1;
         total++;
         if ({read_addrs[0].valid, read_addrs[0].addr, read_addrs[1].addr} !== {1'b1, 32'h8, 32'hC}) begin
            bad++; $display("FAIL s0miss_hold cyc%0d: got %h/%h want 8/c", k, read_addrs[0].addr, read_addrs[1].addr);
         end
         tick();
      end
      drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1, mk(32'h8), mk(32'hC));
      tick();
      drive(1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 1'b0, 64'h0, 64'h0);
      #1;
      total++;
      if (read_addrs[0].addr !== 32'h10) begin
         bad++; $display("FAIL s0miss_resume: got %h want 10", read_addrs[0].addr);
      end
      tick();
      drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 64'h0, 64'h0);
      #1;
      total++;
      if ({dec_valid, dec_pc, dec_inst} !== {2'b11, 32'hC, 32'h8, tagw(32'hC), tagw(32'h8)}) begin
         bad++; $display("FAIL s0miss_order: got dv=%b pc=%h inst=%h", dec_valid, dec_pc, dec_inst);
      end
   endtask

   task automatic test_fill();
      logic [31:0] pc;
      do_reset();
      pc = 32'h0;
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1, mk(pc), mk(pc + 32'h4));
         #1;
         total++;
         if (read_addrs[0].valid !== 1'b1) begin
            bad++; $display("FAIL fill_lookup k%0d: got %b want 1", k, read_addrs[0].valid);
         end
         tick();
         pc = pc + 32'h8;
      end
      drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1, mk(pc), mk(pc + 32'h4));
      #1;
      total++;
      if ({read_addrs[0].valid, read_addrs[1].valid, dec_valid} !== 4'b0011) begin
         bad++; $display("FAIL fill_full: got rv=%b%b dv=%b want 00 11", read_addrs[0].valid, read_addrs[1].valid, dec_valid);
      end
      tick();
      drive(1'b0, 1'b0, 32'h0, 2'd2, 1'b1, 1'b1, mk(pc), mk(pc + 32'h4));
      #1;
      total++;
      if ({read_addrs[0].valid, dec_pc} !== {1'b0, 32'h4, 32'h0}) begin
         bad++; $display("FAIL fill_pop: got rv=%b pc=%h want 0 4/0", read_addrs[0].valid, dec_pc);
      end
      tick();
      drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 64'h0, 64'h0);
      #1;
      total++;
      if ({read_addrs[0].valid, read_addrs[0].addr, dec_pc} !== {1'b1, 32'h20, 32'hC, 32'h8}) begin
         bad++; $display("FAIL fill_resume: got rv=%b a0=%h pc=%h want 1 20 c/8", read_addrs[0].valid, read_addrs[0].addr, dec_pc);
      end
   endtask

   task automatic test_redirect();
      logic [31:0] pc;
      do_reset();
      pc = 32'h0;
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1, mk(pc), mk(pc + 32'h4));
         tick();
         pc = pc + 32'h8;
      end
      drive(1'b0, 1'b1, 32'h100, 2'd2, 1'b1, 1'b1, mk(pc), mk(pc + 32'h4));
      #1;
      total++;
      if ({read_addrs[0].valid, read_addrs[1].valid} !== 2'b00) begin
         bad++; $display("FAIL redir_lookup: got %b%b want 00", read_addrs[0].valid, read_addrs[1].valid);
      end
      tick();
      drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 64'h0, 64'h0);
      #1;
      total++;
      if ({dec_valid, dec_inst, dec_pc} !== '0) begin
         bad++; $display("FAIL redir_flush: got dv=%b i=%h p=%h want 0", dec_valid, dec_inst, dec_pc);
      end
      total++;
      if ({read_addrs[0].valid, read_addrs[0].addr, read_addrs[1].addr} !== {1'b1, 32'h100, 32'h104}) begin
         bad++; $display("FAIL redir_target: got %h/%h want 100/104", read_addrs[0].addr, read_addrs[1].addr);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] pc;
      do_reset();
      pc = 32'h0;
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1, mk(pc), mk(pc + 32'h4));
         tick();
         pc = pc + 32'h8;
      end
      drive(1'b0, 1'b0, 32'h0, 2'd2, 1'b1, 1'b0, mk(pc), 64'h0);
      tick();
      pc = pc + 32'h4;
      drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1, mk(pc), mk(pc + 32'h4));
      #1;
      total++;
      if ({read_addrs[0].valid, read_addrs[0].addr} !== {1'b1, 32'h1C}) begin
         bad++; $display("FAIL wrap_lookup: got rv=%b a0=%h want 1 1c", read_addrs[0].valid, read_addrs[0].addr);
      end
      tick();
      for (int k = 0; k < 7; k++) begin
         drive(1'b0, 1'b0, 32'h0, 2'd1, 1'b0, 1'b0, 64'h0, 64'h0);
         #1;
         total++;
         if ({dec_valid[0], dec_pc[0], dec_inst[0]} !== {1'b1, 32'(8 + 4 * k), tagw(32'(8 + 4 * k))}) begin
            bad++; $display("FAIL wrap_order k%0d: got v=%b pc=%h inst=%h", k, dec_valid[0], dec_pc[0], dec_inst[0]);
         end
         tick();
      end
      drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 64'h0, 64'h0);
      #1;
      total++;
      if (dec_valid !== 2'b00) begin
         bad++; $display("FAIL wrap_drained: got %b want 00", dec_valid);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1, 64'h1234, 64'h5678);
         tick();
      end
      drive(1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1, 64'h1234, 64'h5678);
      #1;
      total++;
      if ({read_addrs, dec_valid, dec_inst, dec_pc} !== '0) begin
         bad++; $display("FAIL midreset_outputs: got ra=%h dv=%b", read_addrs, dec_valid);
      end
      tick();
      drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 64'h0, 64'h0);
      #1;
      total++;
      if ({dec_valid, read_addrs[0].addr, read_addrs[1].addr} !== {2'b00, 32'h0, 32'h4}) begin
         bad++; $display("FAIL midreset_discard: got dv=%b a=%h/%h want 00 0/4", dec_valid, read_addrs[0].addr, read_addrs[1].addr);
      end
   endtask

   task automatic test_random();
      logic [31:0] rpc;
      logic [31:0] ea;
      logic        elv;
      logic        edv;
      logic [31:0] ei;
      logic [31:0] ep;
      for (int c = 0; c < 3000; c++) begin
         rpc = $urandom();
         rpc[1:0] = 2'b00;
         drive($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0, rpc,
               2'($urandom_range(0, 2)), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
               {$urandom(), $urandom()}, {$urandom(), $urandom()});
         #1;
         elv = !reset && !redirect_valid && ((DEPTH - m_inst.size()) >= 2);
         for (int i = 0; i < 2; i++) begin
            ea = m_fpc + 32'(4 * i);
            total++;
            if (reset) begin
               if (read_addrs[i] !== '0) begin
                  bad++; $display("FAIL rnd_addr_rst c%0d s%0d: got %h want 0", c, i, read_addrs[i]);
               end
            end else if ({read_addrs[i].valid, read_addrs[i].addr,
                          read_addrs[i].zeros, read_addrs[i].tag, read_addrs[i].block_offset} !== {elv, ea, ea}) begin
               bad++; $display("FAIL rnd_addr c%0d s%0d: got v=%b a=%h want v=%b a=%h",
                               c, i, read_addrs[i].valid, read_addrs[i].addr, elv, ea);
            end
            edv = !reset && (m_inst.size() > i);
            ei  = 32'h0;
            ep  = 32'h0;
            if (edv) begin
               ei = m_inst[i];
               ep = m_pc[i];
            end
            total++;
            if ({dec_valid[i], dec_inst[i], dec_pc[i]} !== {edv, ei, ep}) begin
               bad++; $display("FAIL rnd_dec c%0d s%0d: got v=%b i=%h p=%h want v=%b i=%h p=%h",
                               c, i, dec_valid[i], dec_inst[i], dec_pc[i], edv, ei, ep);
            end
         end
         tick();
      end
   endtask

   initial begin
      m_fpc = 32'h0;
      drive(1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 64'h0, 64'h0);
      @(negedge clock);
      test_reset();
      test_double_hit();
      test_slot1_miss();
      test_slot0_miss();
      test_fill();
      test_redirect();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter FETCH_BUF_DEPTH, default 8, instruction buffer entries (power of two, >= 4).
REQ-002 Parameter RESET_PC, default 32'h0, PC loaded at reset.
REQ-003 clock  input  1  sole clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 redirect_valid  input  1  branch/exception redirect this cycle.
REQ-006 redirect_pc  input  32  target PC, word-aligned.
REQ-007 read_addrs  output  I_ADDR_PACKET[1:0]  icache lookups; [0] is older.
REQ-008 cache_outs  input  CACHE_DATA[1:0]  icache results, same cycle; valid = hit.
REQ-009 dec_ready  input  2  number of instructions decode accepts this cycle (0..2).
REQ-010 dec_valid  output  2  dec_valid[i] = slot i carries an instruction; [0] is older.
REQ-011 dec_inst  output  32x2  instruction words.
REQ-012 dec_pc  output  32x2  PCs of the instructions.

Function
REQ-013 Fetch PC register fpc; read_addrs[0].addr = fpc, read_addrs[1].addr = fpc+4; zeros, tag and block_offset fields come from the address bits.
REQ-014 Both read_addrs valid = 1 only when the buffer has >= 2 free entries, redirect_valid = 0 and reset = 0; otherwise both are 0.
REQ-015 Word select: instruction = cache_outs[i].data[63:32] when the slot address bit 2 = 1, else data[31:0].
REQ-016 In-order capture: push slot 0 when its lookup hits; push slot 1 only when slot 0 and slot 1 both hit; never push slot 1 without slot 0.
REQ-017 fpc advances by 4 x (pushed count): 0, 4 or 8; 32-bit wrap-around permitted.
REQ-018 A slot-0 miss leaves fpc unchanged and re-presents the same address the next cycle; the downstream MSHR/prefetcher dedups.
REQ-019 Buffer: circular FIFO, head/tail pointers, occupancy count width clog2(DEPTH)+1; each entry holds {inst, pc}.
REQ-020 dec_valid[0] = count >= 1 and dec_valid[1] = count >= 2; the outputs show the head and head+1 entries combinationally (zero latency).
REQ-021 Pop count = min(dec_ready, count); pop and push in the same cycle are both honoured, and count_next = count + push - pop.
REQ-022 Full (free < 2): no lookups and no push; a pop still proceeds.
REQ-023 Empty: dec_valid = 0 and dec_inst/dec_pc = 0.
REQ-024 Redirect wins over push and pop: head = tail = count = 0, fpc = redirect_pc, no push, dec_ready ignored; the first lookup from redirect_pc occurs the next cycle.
REQ-025 Pointers wrap modulo FETCH_BUF_DEPTH; a two-entry push straddling the wrap writes entries DEPTH-1 and 0.

Reset
REQ-026 When reset = 1 at posedge: fpc = RESET_PC, head = tail = count = 0, all buffer entries = 0.
REQ-027 While reset is high: read_addrs = 0, dec_valid = 0, dec_inst = 0, dec_pc = 0.
REQ-028 Reset mid-operation discards all buffered instructions; no entry survives.

Structure
REQ-029 I_ADDR_PACKET, CACHE_DATA, MEM_BLOCK and a new FETCH_ENTRY {inst[31:0], pc[31:0]} typedef live in sys_defs.svh; FETCH_BUF_DEPTH is a `define there.
REQ-030 One sub-module, fetch_buffer (2-in/2-out FIFO with flush), contains the storage and pointers; fetch_stage holds fpc and the hit/select logic.

Verification
REQ-031 Reset, RESET_PC=0, both lookups hit with blocks 0 -> cycle 1 read_addrs = 0x0/0x4, two entries pushed, fpc = 0x8.
REQ-032 Slot 0 hit, slot 1 miss at fpc=0x4 -> one push (pc 0x4), fpc = 0x8; next read_addrs = 0x8/0xC.
REQ-033 Slot 0 miss for 5 cycles -> fpc holds, no push, read_addrs repeat; hit on cycle 6 -> resume.
REQ-034 Fill the buffer with dec_ready = 0 -> after 4 double pushes count = 8 and read_addrs.valid = 0; dec_ready = 2 -> pops 2 and lookups resume the next cycle.
REQ-035 Redirect to 0x100 with 6 buffered entries and simultaneous hits -> next cycle count = 0, dec_valid = 0, read_addrs = 0x100/0x104.
REQ-036 DEPTH=8, tail=7, double push -> entries 7 and 0 are written; dec order is preserved across the wrap with dec_ready = 1 each cycle.
